// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with per-register pending-write scoreboard.
// Define RF_WB_RR_ARB_EN for round-robin ALU/LD arbitration; default is fixed ALU priority.
module rf_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          rf_write_en,
  output logic [AW-1:0] rf_write_addr,
  output logic [DW-1:0] rf_write_val,
  input  logic          rsv_valid,
  output logic          rsv_ready,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] chk_rs1,
  input  logic [AW-1:0] chk_rs2,
  output logic          chk_stall,
  output logic          wb_err
);

  logic          grant_alu;
  logic          grant_ld;
  logic          wb_fire;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rsv_fire;
  logic          wb_unreserved;
  logic [1:0]    count_reg  [NREG];
  logic [1:0]    count_next [NREG];

`ifdef RF_WB_RR_ARB_EN
  // ptr_reg low means the ALU wins the next contested cycle.
  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    ptr_next  = ptr_reg;
    if (!reset) begin
      grant_alu = alu_valid && (!ld_valid || !ptr_reg);
      grant_ld  = ld_valid && (!alu_valid || ptr_reg);
      if (alu_valid && ld_valid) begin
        ptr_next = grant_alu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (!reset) begin
      grant_alu = alu_valid;
      grant_ld  = ld_valid && !alu_valid;
    end
  end
`endif

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;
  assign wb_fire   = grant_alu || grant_ld;
  assign wb_addr   = grant_alu ? alu_addr : ld_addr;
  assign wb_data   = grant_alu ? alu_data : ld_data;

  assign rsv_ready     = (count_reg[rsv_addr] != 2'd3);
  assign rsv_fire      = rsv_valid && rsv_ready && !reset;
  assign wb_unreserved = wb_fire && (wb_addr != '0) && (count_reg[wb_addr] == 2'd0);

  assign chk_stall = ((chk_rs1 != '0) && (count_reg[chk_rs1] != 2'd0)) ||
                     ((chk_rs2 != '0) && (count_reg[chk_rs2] != 2'd0));

  // A reservation and a writeback on the same register cancel out.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_count
      if (gi == 0) begin : g_zero
        assign count_next[gi] = 2'd0;
      end else begin : g_reg
        logic rsv_hit;
        logic wb_hit;
        assign rsv_hit = rsv_fire && (rsv_addr == AW'(gi));
        assign wb_hit  = wb_fire && (wb_addr == AW'(gi));
        assign count_next[gi] =
          (rsv_hit && !wb_hit) ? count_reg[gi] + 2'd1 :
          (wb_hit && !rsv_hit && count_reg[gi] != 2'd0) ? count_reg[gi] - 2'd1 :
          count_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        count_reg[i] <= 2'd0;
      end
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_val  <= '0;
      wb_err        <= 1'b0;
    end else begin
      count_reg   <= count_next;
      rf_write_en <= wb_fire;
      if (wb_fire) begin
        rf_write_addr <= wb_addr;
        rf_write_val  <= wb_data;
      end
      if (wb_unreserved) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (both arbitration builds).
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          rf_write_en;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_val;
  logic          rsv_valid, rsv_ready;
  logic [AW-1:0] rsv_addr;
  logic [AW-1:0] chk_rs1, chk_rs2;
  logic          chk_stall;
  logic          wb_err;

  int n_checks = 0;
  int n_fails  = 0;

  rf_wb_arbiter #(.NREG(32), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_val(rf_write_val),
    .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_stall(chk_stall),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    rsv_valid = 0; rsv_addr = 0;
    chk_rs1 = 0; chk_rs2 = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
    settle();
  endtask

  logic exp_alu [4];
  logic [DW-1:0] exp_val;

  initial begin
    do_reset();
    check("reset_wr_en", rf_write_en, 0);
    check("reset_wr_addr", rf_write_addr, 0);
    check("reset_wr_val", rf_write_val, 0);
    check("reset_wb_err", wb_err, 0);
    chk_rs1 = 5; settle();
    check("reset_stall", chk_stall, 0);

    // Reserve r5, ALU writeback r5
    rsv_valid = 1; rsv_addr = 5; settle();
    check("r5_rsv_ready", rsv_ready, 1);
    step();
    rsv_valid = 0; settle();
    check("r5_stall_pending", chk_stall, 1);
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; settle();
    check("r5_alu_ready", alu_ready, 1);
    check("r5_ld_ready", ld_ready, 0);
    step();
    alu_valid = 0; settle();
    check("r5_wr_en", rf_write_en, 1);
    check("r5_wr_addr", rf_write_addr, 5);
    check("r5_wr_val", rf_write_val, 32'hDEADBEEF);
    check("r5_stall_clear", chk_stall, 0);
    check("r5_no_err", wb_err, 0);
    step();
    check("r5_wr_en_drop", rf_write_en, 0);
    check("r5_addr_hold", rf_write_addr, 5);

    // Reserve r7 three times to saturate
    do_reset();
    rsv_valid = 1; rsv_addr = 7;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("r7_rsv_ready", rsv_ready, 1);
      step();
    end
    check("r7_full", rsv_ready, 0);
    step();
    rsv_valid = 0; chk_rs1 = 7; settle();
    check("r7_full_hold", rsv_ready, 0);
    check("r7_stall", chk_stall, 1);
    ld_valid = 1; ld_addr = 7; ld_data = 32'h77; settle();
    check("r7_ld_ready", ld_ready, 1);
    step();
    ld_valid = 0; settle();
    check("r7_rsv_ready_after_wb", rsv_ready, 1);
    check("r7_wr_addr", rf_write_addr, 7);
    check("r7_no_err", wb_err, 0);

    // Contested grants (writes to r0 so no scoreboard side effects)
    do_reset();
`ifdef RF_WB_RR_ARB_EN
    exp_alu[0] = 1; exp_alu[1] = 0; exp_alu[2] = 1; exp_alu[3] = 0;
`else
    exp_alu[0] = 1; exp_alu[1] = 1; exp_alu[2] = 1; exp_alu[3] = 1;
`endif
    alu_valid = 1; alu_addr = 0; alu_data = 32'hA;
    ld_valid = 1; ld_addr = 0; ld_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("arb_alu_ready", alu_ready, exp_alu[i]);
      check("arb_ld_ready", ld_ready, !exp_alu[i]);
      exp_val = exp_alu[i] ? 32'hA : 32'hB;
      step();
      check("arb_wr_val", rf_write_val, exp_val);
    end
    idle(); settle();
    check("arb_r0_no_err", wb_err, 0);

    // Same-cycle reserve and writeback on r3 with count 1
    do_reset();
    rsv_valid = 1; rsv_addr = 3;
    step();
    ld_valid = 1; ld_addr = 3; ld_data = 32'h33; settle();
    check("r3_ld_ready", ld_ready, 1);
    check("r3_rsv_ready", rsv_ready, 1);
    step();
    idle(); chk_rs2 = 3; settle();
    check("r3_stall", chk_stall, 1);
    check("r3_wr_val", rf_write_val, 32'h33);
    check("r3_no_err", wb_err, 0);
    ld_valid = 1; ld_addr = 3; settle();
    step();
    ld_valid = 0; settle();
    check("r3_stall_clear", chk_stall, 0);
    check("r3_no_err_final", wb_err, 0);

    // Unreserved writeback r9, then r0 writes
    do_reset();
    ld_valid = 1; ld_addr = 9; ld_data = 32'h99; settle();
    check("r9_ld_ready", ld_ready, 1);
    step();
    ld_valid = 0; settle();
    check("r9_wr_en", rf_write_en, 1);
    check("r9_wr_addr", rf_write_addr, 9);
    check("r9_wb_err", wb_err, 1);
    step();
    check("r9_wb_err_sticky", wb_err, 1);
    alu_valid = 1; alu_addr = 0; alu_data = 32'h1234;
    step();
    alu_valid = 0; chk_rs1 = 0; settle();
    check("r0_wr_addr", rf_write_addr, 0);
    check("r0_wr_val", rf_write_val, 32'h1234);
    check("r0_err_unchanged", wb_err, 1);
    check("r0_stall", chk_stall, 0);
    do_reset();
    alu_valid = 1; alu_addr = 0; alu_data = 32'h5;
    step();
    alu_valid = 0; settle();
    check("r0_fresh_no_err", wb_err, 0);

    // Reset overrides reservation and writeback
    do_reset();
    ld_valid = 1; ld_addr = 9; step();
    ld_valid = 0;
    rsv_valid = 1; rsv_addr = 4; step();
    rsv_valid = 0; settle();
    check("rst_pre_err", wb_err, 1);
    reset = 1; alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    rsv_valid = 1; rsv_addr = 4; settle();
    check("rst_alu_ready", alu_ready, 0);
    step();
    reset = 0; idle(); chk_rs1 = 4; settle();
    check("rst_wr_en", rf_write_en, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_stall_r4", chk_stall, 0);
    check("rst_wr_val", rf_write_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
